// File: rtl/alu32_seq_if.sv
// Request/response bundle for alu32_seq: operation request in, registered result and status out.
interface alu32_seq_if;
  logic        start;
  logic [3:0]  aluop;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] result;
  logic        zero;
  logic        busy;
  logic        done;

  modport master (
    output start, aluop, a, b,
    input  result, zero, busy, done
  );

  modport slave (
    input  start, aluop, a, b,
    output result, zero, busy, done
  );
endinterface

// File: rtl/alu32_seq.sv
// 32-bit ALU: single-cycle logic/arith ops plus an optional 32-cycle shift-add multiply.
// Multiply is built only when ALU32_SEQ_MUL_EN is defined; otherwise aluop 1000 is undefined.
module alu32_seq (
  input  logic       clk,
  input  logic       rst_n,
  alu32_seq_if.slave bus
);

  localparam logic [3:0] OpAnd = 4'b0000;
  localparam logic [3:0] OpOr  = 4'b0001;
  localparam logic [3:0] OpAdd = 4'b0010;
  localparam logic [3:0] OpSub = 4'b0110;
  localparam logic [3:0] OpSlt = 4'b0111;

  logic [31:0] result_q, result_d;
  logic        zero_q, zero_d;
  logic        done_q, done_d;
  logic [31:0] alu_res;

`ifdef ALU32_SEQ_MUL_EN
  localparam logic [3:0] OpMul = 4'b1000;

  typedef enum logic [0:0] {StIdle, StMul} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [31:0] acc_sum;

  assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : 32'd0);
`endif

  // Undefined opcodes (and MUL, which never goes through this path) yield zero.
  always_comb begin
    alu_res = 32'd0;
    case (bus.aluop)
      OpAnd:   alu_res = bus.a & bus.b;
      OpOr:    alu_res = bus.a | bus.b;
      OpAdd:   alu_res = bus.a + bus.b;
      OpSub:   alu_res = bus.a - bus.b;
      OpSlt:   alu_res = ($signed(bus.a) < $signed(bus.b)) ? 32'd1 : 32'd0;
      default: alu_res = 32'd0;
    endcase
  end

  always_comb begin
    result_d = result_q;
    zero_d   = zero_q;
    done_d   = 1'b0;
`ifdef ALU32_SEQ_MUL_EN
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    if (state_q == StMul) begin
      acc_d    = acc_sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 5'd1;
      if (cnt_q == 5'd31) begin
        result_d = acc_sum;
        zero_d   = (acc_sum == 32'd0);
        done_d   = 1'b1;
        state_d  = StIdle;
      end
    end else
`endif
    if (bus.start) begin
`ifdef ALU32_SEQ_MUL_EN
      if (bus.aluop == OpMul) begin
        mcand_d  = bus.a;
        mplier_d = bus.b;
        acc_d    = 32'd0;
        cnt_d    = 5'd0;
        state_d  = StMul;
      end else
`endif
      begin
        result_d = alu_res;
        zero_d   = (alu_res == 32'd0);
        done_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= 32'd0;
      zero_q   <= 1'b1;
      done_q   <= 1'b0;
`ifdef ALU32_SEQ_MUL_EN
      state_q  <= StIdle;
      cnt_q    <= 5'd0;
      acc_q    <= 32'd0;
      mcand_q  <= 32'd0;
      mplier_q <= 32'd0;
`endif
    end else begin
      result_q <= result_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
`ifdef ALU32_SEQ_MUL_EN
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
`endif
    end
  end

  assign bus.result = result_q;
  assign bus.zero   = zero_q;
  assign bus.done   = done_q;
`ifdef ALU32_SEQ_MUL_EN
  assign bus.busy   = (state_q == StMul);
`else
  assign bus.busy   = 1'b0;
`endif

endmodule
